// File: rtl/branch_resolver.sv
// branch_resolver: execute-stage branch resolution and predictor feedback.
// Compares the decode-time prediction against the ALU outcome.
// It drives the registered predictor feedback bus and the fetch
// redirect, and holds the wrong-path flush window.
//
// Ports:
//   clock, reset           rising-edge clock, async active-low reset
//   ex_valid, ex_stall     execute slot live / frozen
//   ex_pc, ex_target       branch PC and taken target
//   ex_is_branch           conditional branch in execute
//   ex_predicted_taken     direction predicted in decode
//   ex_actual_taken        direction resolved by the ALU
//   past_*                 feedback bus into the predictor
//   redirect_valid/_pc     one-cycle fetch redirect
//   flush                  squash fetch/decode
//   branch_count           resolved branches (saturating)
//   mispredict_count       mispredicts (saturating)
//
// Build option: define BRANCH_STATS_EN to build the statistics counters.
// When it is undefined both counter ports read 0 and no flops are built.

module branch_resolver #(
    parameter int PC_W         = 32,
    parameter int PC_INC       = 1,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ex_valid,
    input  logic             ex_stall,
    input  logic [PC_W-1:0]  ex_pc,
    input  logic             ex_is_branch,
    input  logic             ex_predicted_taken,
    input  logic             ex_actual_taken,
    input  logic [PC_W-1:0]  ex_target,
    output logic [PC_W-1:0]  past_pc,
    output logic             past_is_branch,
    output logic             past_wrong,
    output logic             past_predicted_taken,
    output logic             redirect_valid,
    output logic [PC_W-1:0]  redirect_pc,
    output logic             flush,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // Counter loads FLUSH_CYCLES-1 so flush is high FLUSH_CYCLES cycles.
    localparam logic [3:0]      FLUSH_INIT = 4'(FLUSH_CYCLES - 1);
    localparam logic [PC_W-1:0] PC_STEP    = PC_W'(PC_INC);

    state_t          state_q;
    logic [3:0]      cnt_q;
    logic [PC_W-1:0] past_pc_q;
    logic            past_is_branch_q;
    logic            past_wrong_q;
    logic            past_pred_q;
    logic            redirect_valid_q;
    logic [PC_W-1:0] redirect_pc_q;
    logic            flush_q;

    logic            resolve;
    logic            wrong;
    logic            mispredict;
    logic [PC_W-1:0] redirect_pc_d;
    logic [PC_W-1:0] fall_through;

    // Anything reaching execute during FLUSH is wrong-path.
    always_comb begin
        resolve    = 1'b0;
        wrong      = 1'b0;
        mispredict = 1'b0;
        if (state_q == RUN && ex_valid && !ex_stall && ex_is_branch) begin
            resolve = 1'b1;
        end
        wrong      = ex_predicted_taken ^ ex_actual_taken;
        mispredict = resolve & wrong;
    end

    // Fall-through wraps modulo 2^PC_W.
    always_comb begin
        fall_through  = ex_pc + PC_STEP;
        redirect_pc_d = redirect_pc_q;
        if (mispredict) begin
            redirect_pc_d = ex_actual_taken ? ex_target : fall_through;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q          <= RUN;
            cnt_q            <= '0;
            past_pc_q        <= '0;
            past_is_branch_q <= 1'b0;
            past_wrong_q     <= 1'b0;
            past_pred_q      <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            flush_q          <= 1'b0;
        end else begin
            past_is_branch_q <= resolve;
            redirect_valid_q <= mispredict;
            redirect_pc_q    <= redirect_pc_d;

            if (resolve) begin
                past_pc_q    <= ex_pc;
                past_wrong_q <= wrong;
                past_pred_q  <= ex_predicted_taken;
            end

            unique case (state_q)
                RUN: begin
                    if (mispredict) begin
                        state_q <= FLUSH;
                        cnt_q   <= FLUSH_INIT;
                        flush_q <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= RUN;
                        flush_q <= 1'b0;
                    end else begin
                        cnt_q   <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= RUN;
                    flush_q <= 1'b0;
                end
            endcase
        end
    end

    assign past_pc              = past_pc_q;
    assign past_is_branch       = past_is_branch_q;
    assign past_wrong           = past_wrong_q;
    assign past_predicted_taken = past_pred_q;
    assign redirect_valid       = redirect_valid_q;
    assign redirect_pc          = redirect_pc_q;
    assign flush                = flush_q;

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] branch_cnt_q;
    logic [CNT_W-1:0] mis_cnt_q;

    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            branch_cnt_q <= '0;
            mis_cnt_q    <= '0;
        end else begin
            if (resolve && branch_cnt_q != '1) begin
                branch_cnt_q <= branch_cnt_q + CNT_W'(1);
            end
            if (mispredict && mis_cnt_q != '1) begin
                mis_cnt_q <= mis_cnt_q + CNT_W'(1);
            end
        end
    end

    assign branch_count     = branch_cnt_q;
    assign mispredict_count = mis_cnt_q;
`else
    assign branch_count     = '0;
    assign mispredict_count = '0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: directed self-checking bench for branch_resolver.
// Expected values are hand-computed per scenario.

module tb_branch_resolver;

    logic        clock;
    logic        reset;
    logic        ex_valid;
    logic        ex_stall;
    logic [31:0] ex_pc;
    logic        ex_is_branch;
    logic        ex_predicted_taken;
    logic        ex_actual_taken;
    logic [31:0] ex_target;
    logic [31:0] past_pc;
    logic        past_is_branch;
    logic        past_wrong;
    logic        past_predicted_taken;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic [1:0]  branch_count;
    logic [1:0]  mispredict_count;

    int tests_run;
    int fails;

    branch_resolver #(
        .PC_W(32),
        .PC_INC(1),
        .FLUSH_CYCLES(2),
        .CNT_W(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .ex_valid(ex_valid),
        .ex_stall(ex_stall),
        .ex_pc(ex_pc),
        .ex_is_branch(ex_is_branch),
        .ex_predicted_taken(ex_predicted_taken),
        .ex_actual_taken(ex_actual_taken),
        .ex_target(ex_target),
        .past_pc(past_pc),
        .past_is_branch(past_is_branch),
        .past_wrong(past_wrong),
        .past_predicted_taken(past_predicted_taken),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .flush(flush),
        .branch_count(branch_count),
        .mispredict_count(mispredict_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        ex_valid           = 1'b0;
        ex_stall           = 1'b0;
        ex_is_branch       = 1'b0;
        ex_predicted_taken = 1'b0;
        ex_actual_taken    = 1'b0;
        ex_pc              = '0;
        ex_target          = '0;
    endtask

    task automatic branch(input logic [31:0] pc, input logic pred,
                          input logic act, input logic [31:0] tgt);
        ex_valid           = 1'b1;
        ex_stall           = 1'b0;
        ex_is_branch       = 1'b1;
        ex_predicted_taken = pred;
        ex_actual_taken    = act;
        ex_pc              = pc;
        ex_target          = tgt;
    endtask

    task automatic test_reset();
        logic [3:0] ctl;
        idle();
        reset = 1'b0;
        tick();
        tick();
        ctl = {past_is_branch, past_wrong, redirect_valid, flush};
        tests_run++;
        if (ctl !== 4'b0000 || past_predicted_taken !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctl: got %b/%b want 0000/0", ctl,
                     past_predicted_taken);
        end
        tests_run++;
        if (past_pc !== 32'h0 || redirect_pc !== 32'h0) begin
            fails++;
            $display("FAIL reset_pc: got %h/%h want 0/0", past_pc, redirect_pc);
        end
        tests_run++;
        if (branch_count !== 2'd0 || mispredict_count !== 2'd0) begin
            fails++;
            $display("FAIL reset_cnt: got %0d/%0d want 0/0", branch_count,
                     mispredict_count);
        end
        #2 reset = 1'b1;
    endtask

    task automatic test_correct();
        branch(32'h40, 1'b1, 1'b1, 32'h100);
        tick();
        idle();
        tests_run++;
        if ({past_is_branch, past_wrong, redirect_valid, flush} !== 4'b1000) begin
            fails++;
            $display("FAIL correct_ctl: got %b want 1000",
                     {past_is_branch, past_wrong, redirect_valid, flush});
        end
        tests_run++;
        if (past_pc !== 32'h40 || past_predicted_taken !== 1'b1) begin
            fails++;
            $display("FAIL correct_pc: got %h/%b want 40/1", past_pc,
                     past_predicted_taken);
        end
        tick();
        tests_run++;
        if (past_is_branch !== 1'b0 || past_pc !== 32'h40) begin
            fails++;
            $display("FAIL correct_hold: got %b/%h want 0/40", past_is_branch,
                     past_pc);
        end
    endtask

    task automatic test_mispredict();
        branch(32'h40, 1'b0, 1'b1, 32'h80);
        tick();
        tests_run++;
        if ({past_is_branch, past_wrong, redirect_valid, flush} !== 4'b1111) begin
            fails++;
            $display("FAIL mis_ctl: got %b want 1111",
                     {past_is_branch, past_wrong, redirect_valid, flush});
        end
        tests_run++;
        if (redirect_pc !== 32'h80) begin
            fails++;
            $display("FAIL mis_rpc: got %h want 80", redirect_pc);
        end
        // Wrong-path mispredicting branch during the flush window.
        branch(32'h200, 1'b1, 1'b0, 32'h999);
        tick();
        tests_run++;
        if ({past_is_branch, redirect_valid, flush} !== 3'b001
            || redirect_pc !== 32'h80) begin
            fails++;
            $display("FAIL mis_flush1: got %b/%h want 001/80",
                     {past_is_branch, redirect_valid, flush}, redirect_pc);
        end
        tick();
        tests_run++;
        if ({past_is_branch, redirect_valid, flush} !== 3'b000
            || past_pc !== 32'h40 || past_wrong !== 1'b1) begin
            fails++;
            $display("FAIL mis_flush2: got %b/%h/%b want 000/40/1",
                     {past_is_branch, redirect_valid, flush}, past_pc,
                     past_wrong);
        end
        branch(32'h300, 1'b0, 1'b0, 32'h0);
        tick();
        idle();
        tests_run++;
        if ({past_is_branch, past_wrong, redirect_valid, flush} !== 4'b1000
            || past_pc !== 32'h300) begin
            fails++;
            $display("FAIL mis_after: got %b/%h want 1000/300",
                     {past_is_branch, past_wrong, redirect_valid, flush},
                     past_pc);
        end
        tick();
    endtask

    task automatic test_wrap();
        branch(32'hFFFF_FFFF, 1'b1, 1'b0, 32'h1234);
        tick();
        idle();
        tests_run++;
        if (redirect_pc !== 32'h0 || redirect_valid !== 1'b1
            || past_wrong !== 1'b1) begin
            fails++;
            $display("FAIL wrap: got %h/%b/%b want 0/1/1", redirect_pc,
                     redirect_valid, past_wrong);
        end
        tick();
        tick();
        tests_run++;
        if (flush !== 1'b0 || redirect_valid !== 1'b0) begin
            fails++;
            $display("FAIL wrap_end: got %b/%b want 0/0", flush, redirect_valid);
        end
    endtask

    task automatic test_stall();
        int pulses;
        pulses = 0;
        branch(32'h500, 1'b1, 1'b1, 32'h0);
        ex_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (past_is_branch === 1'b1) pulses++;
        end
        tests_run++;
        if (pulses != 0) begin
            fails++;
            $display("FAIL stall_held: got %0d pulses want 0", pulses);
        end
        ex_stall = 1'b0;
        tick();
        idle();
        tests_run++;
        if (past_is_branch !== 1'b1 || past_pc !== 32'h500) begin
            fails++;
            $display("FAIL stall_release: got %b/%h want 1/500",
                     past_is_branch, past_pc);
        end
        tick();
        tests_run++;
        if (past_is_branch !== 1'b0) begin
            fails++;
            $display("FAIL stall_once: got %b want 0", past_is_branch);
        end
    endtask

    task automatic test_reset_midflush();
        branch(32'h600, 1'b0, 1'b1, 32'h700);
        tick();
        idle();
        tests_run++;
        if (flush !== 1'b1) begin
            fails++;
            $display("FAIL rst_pre: got flush %b want 1", flush);
        end
        #2 reset = 1'b0;
        #1;
        tests_run++;
        if ({past_is_branch, past_wrong, past_predicted_taken,
             redirect_valid, flush} !== 5'b0
            || past_pc !== 32'h0 || redirect_pc !== 32'h0
            || branch_count !== 2'd0 || mispredict_count !== 2'd0) begin
            fails++;
            $display("FAIL rst_async: got %b/%h/%h want 00000/0/0",
                     {past_is_branch, past_wrong, past_predicted_taken,
                      redirect_valid, flush}, past_pc, redirect_pc);
        end
        #1 reset = 1'b1;
        branch(32'h40, 1'b1, 1'b1, 32'h0);
        tick();
        idle();
        tests_run++;
        if (past_is_branch !== 1'b1 || flush !== 1'b0) begin
            fails++;
            $display("FAIL rst_run: got %b/%b want 1/0", past_is_branch, flush);
        end
        tick();
    endtask

    task automatic test_stats();
        logic [1:0] exp_bc [5];
        logic [1:0] exp_mc [5];
        logic       mis    [5];
`ifdef BRANCH_STATS_EN
        exp_bc = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        exp_mc = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
`else
        exp_bc = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
        exp_mc = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif
        mis = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        reset = 1'b0;
        #2 reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            branch(32'h1000 + 32'(i), 1'b0, mis[i], 32'h2000);
            tick();
            idle();
            tests_run++;
            if (branch_count !== exp_bc[i] || mispredict_count !== exp_mc[i]) begin
                fails++;
                $display("FAIL stats_%0d: got %0d/%0d want %0d/%0d", i,
                         branch_count, mispredict_count, exp_bc[i], exp_mc[i]);
            end
            tick();
            tick();
        end
    endtask

    initial begin
        tests_run = 0;
        fails     = 0;
        reset     = 1'b0;
        idle();
        test_reset();
        test_correct();
        test_mispredict();
        test_wrap();
        test_stall();
        test_reset_midflush();
        test_stats();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
